elastic_pipeline_stage: RTL and testbench

- Successor to the plain stall/flush pipeline register.
- Adds a valid/ready handshake with a 2-entry skid buffer, so upstream ready is fully registered and no combinational path runs from ready_i to ready_o.
- Keeps the existing stall (freeze) and synchronous flush (clear) semantics.
- Sits between pipeline stages, or between the core and multi-cycle units (memory, divider).

---
 rtl/elastic_pipeline_stage.sv | 159 +++++++++++++++
 tb/tb_elastic_pipeline_stage.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/elastic_pipeline_stage.sv
`default_nettype none
// ============================================================================
// Module      : elastic_pipeline_stage
// Description : Elastic pipeline register with a valid/ready handshake and a
//               2-entry skid buffer. Upstream ready depends only on the
//               registered state and stall_i, never on ready_i. The stage
//               supports a freeze (stall_i) and a synchronous clear (flush_i).
//
// Ports       : clk          - pipeline clock, rising edge
//               rst_n        - asynchronous active-low reset
//               flush_i      - synchronous flush, highest priority
//               stall_i      - freeze: blocks accept and output transfer
//               valid_i      - upstream beat valid
//               data_i       - upstream payload [WIDTH-1:0]
//               ready_o      - stage can accept a beat
//               valid_o      - data_o holds a valid beat
//               data_o       - downstream payload, straight from main register
//               ready_i      - downstream accepts a beat
//               occupancy_o  - entries held (0, 1 or 2)
//               bp_cycles_o  - [ELASTIC_STAGE_PERF_CNT_EN] back-pressure cycles
//               xfer_count_o - [ELASTIC_STAGE_PERF_CNT_EN] output transfers
//
// Options     : `define ELASTIC_STAGE_PERF_CNT_EN adds the two saturating
//               32-bit performance counters above.
//
// Revision    : 1.0 - initial release
// ============================================================================
module elastic_pipeline_stage #(
    parameter int                 WIDTH     = 32,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              stall_i,
    input  logic              valid_i,
    input  logic [WIDTH-1:0]  data_i,
    output logic              ready_o,
    output logic              valid_o,
    output logic [WIDTH-1:0]  data_o,
    input  logic              ready_i,
`ifdef ELASTIC_STAGE_PERF_CNT_EN
    output logic [31:0]       bp_cycles_o,
    output logic [31:0]       xfer_count_o,
`endif
    output logic [1:0]        occupancy_o
);

    // State encoding doubles as the entry count.
    localparam logic [1:0] c_st_empty = 2'd0;
    localparam logic [1:0] c_st_busy  = 2'd1;
    localparam logic [1:0] c_st_full  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] main_q,  main_d;
    logic [WIDTH-1:0] skid_q,  skid_d;

    logic             w_accept;
    logic             w_xfer;

    // ready_o depends on registered state and stall_i only: no path from ready_i.
    assign ready_o     = (state_q != c_st_full) && !stall_i;
    assign valid_o     = (state_q == c_st_busy) || (state_q == c_st_full);
    assign data_o      = main_q;
    assign occupancy_o = (state_q == c_st_full) ? 2'd2 :
                         (state_q == c_st_busy) ? 2'd1 : 2'd0;

    assign w_accept = valid_i && ready_o;
    assign w_xfer   = valid_o && ready_i && !stall_i;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush_i) begin
            state_d = c_st_empty;
            main_d  = RESET_VAL;
            skid_d  = RESET_VAL;
        end else begin
            // stall_i already forces w_accept and w_xfer low, so a stalled
            // cycle falls through every branch as a hold.
            case (state_q)
                c_st_empty: begin
                    if (w_accept) begin
                        state_d = c_st_busy;
                        main_d  = data_i;
                    end
                end
                c_st_busy: begin
                    if (w_accept && !w_xfer) begin
                        state_d = c_st_full;
                        skid_d  = data_i;
                    end else if (w_accept && w_xfer) begin
                        main_d  = data_i;
                    end else if (w_xfer) begin
                        // main keeps the drained value; consumers qualify with valid_o
                        state_d = c_st_empty;
                    end
                end
                c_st_full: begin
                    if (w_xfer) begin
                        state_d = c_st_busy;
                        main_d  = skid_q;
                        skid_d  = RESET_VAL;
                    end
                end
                default: begin
                    state_d = c_st_empty;
                    main_d  = RESET_VAL;
                    skid_d  = RESET_VAL;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= c_st_empty;
            main_q  <= RESET_VAL;
            skid_q  <= RESET_VAL;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

`ifdef ELASTIC_STAGE_PERF_CNT_EN
    logic [31:0] bp_cycles_q,  bp_cycles_d;
    logic [31:0] xfer_count_q, xfer_count_d;

    // Counters observe the handshake only; flush does not clear them.
    always_comb begin
        bp_cycles_d  = bp_cycles_q;
        xfer_count_d = xfer_count_q;
        if (valid_o && !w_xfer && (bp_cycles_q != 32'hFFFF_FFFF)) begin
            bp_cycles_d = bp_cycles_q + 32'd1;
        end
        if (w_xfer && (xfer_count_q != 32'hFFFF_FFFF)) begin
            xfer_count_d = xfer_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bp_cycles_q  <= 32'd0;
            xfer_count_q <= 32'd0;
        end else begin
            bp_cycles_q  <= bp_cycles_d;
            xfer_count_q <= xfer_count_d;
        end
    end

    assign bp_cycles_o  = bp_cycles_q;
    assign xfer_count_o = xfer_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_elastic_pipeline_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_elastic_pipeline_stage
// Description : Self-checking bench for elastic_pipeline_stage. A queue-based
//               model of the stage (at most two beats in FIFO order plus the
//               last drained value) is checked against the DUT on every
//               falling edge; directed sequences add literal expectations and
//               a randomized phase follows.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_elastic_pipeline_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush_i;
    logic        stall_i;
    logic        valid_i;
    logic [31:0] data_i;
    logic        ready_o;
    logic        valid_o;
    logic [31:0] data_o;
    logic        ready_i;
    logic [1:0]  occupancy_o;
`ifdef ELASTIC_STAGE_PERF_CNT_EN
    logic [31:0] bp_cycles_o;
    logic [31:0] xfer_count_o;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    elastic_pipeline_stage #(.WIDTH(32), .RESET_VAL(32'h0)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush_i),
        .stall_i     (stall_i),
        .valid_i     (valid_i),
        .data_i      (data_i),
        .ready_o     (ready_o),
        .valid_o     (valid_o),
        .data_o      (data_o),
        .ready_i     (ready_i),
`ifdef ELASTIC_STAGE_PERF_CNT_EN
        .bp_cycles_o (bp_cycles_o),
        .xfer_count_o(xfer_count_o),
`endif
        .occupancy_o (occupancy_o)
    );

    // ---------------- behavioural model ----------------
    logic [31:0] mq[$];
    logic [31:0] m_last;
    logic [31:0] m_bp;
    logic [31:0] m_xc;
    int          m_n;
    bit          m_x;
    bit          m_a;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_last = 32'h0;
            m_bp   = 32'h0;
            m_xc   = 32'h0;
        end else begin
            m_n = mq.size();
            m_x = (m_n > 0) && ready_i && !stall_i;
            m_a = valid_i && (m_n < 2) && !stall_i;
            if ((m_n > 0) && !m_x && (m_bp != 32'hFFFF_FFFF)) m_bp = m_bp + 1;
            if (m_x && (m_xc != 32'hFFFF_FFFF)) m_xc = m_xc + 1;
            if (flush_i) begin
                mq.delete();
                m_last = 32'h0;
            end else begin
                if (m_x) m_last = mq.pop_front();
                if (m_a) mq.push_back(data_i);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: model vs DUT every falling edge.
    always @(negedge clk) begin
        chk("model valid_o", {31'b0, valid_o}, {31'b0, mq.size() > 0});
        chk("model ready_o", {31'b0, ready_o}, {31'b0, (mq.size() < 2) && !stall_i});
        chk("model occupancy_o", {30'b0, occupancy_o}, mq.size());
        chk("model data_o", data_o, (mq.size() > 0) ? mq[0] : m_last);
`ifdef ELASTIC_STAGE_PERF_CNT_EN
        chk("model bp_cycles_o", bp_cycles_o, m_bp);
        chk("model xfer_count_o", xfer_count_o, m_xc);
`endif
    end

    // One clock: apply inputs, wait for the edge, land just after the next falling edge.
    task automatic step(input logic v, input logic [31:0] d, input logic r,
                        input logic s, input logic f);
        valid_i = v;
        data_i  = d;
        ready_i = r;
        stall_i = s;
        flush_i = f;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        // ---- reset ----
        rst_n   = 1'b0;
        valid_i = 1'b1;
        data_i  = 32'hDEAD_BEEF;
        ready_i = 1'b0;
        stall_i = 1'b0;
        flush_i = 1'b0;
        #1;
        chk("reset valid_o", {31'b0, valid_o}, 32'd0);
        chk("reset ready_o", {31'b0, ready_o}, 32'd1);
        chk("reset occupancy_o", {30'b0, occupancy_o}, 32'd0);
        chk("reset data_o", data_o, 32'h0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        // ---- streaming ----
        step(1'b1, 32'h1, 1'b1, 1'b0, 1'b0);
        chk("stream beat1", data_o, 32'h1);
        chk("stream occ1", {30'b0, occupancy_o}, 32'd1);
        step(1'b1, 32'h2, 1'b1, 1'b0, 1'b0);
        chk("stream beat2", data_o, 32'h2);
        chk("stream occ2", {30'b0, occupancy_o}, 32'd1);
        step(1'b1, 32'h3, 1'b1, 1'b0, 1'b0);
        chk("stream beat3", data_o, 32'h3);
        chk("stream occ3", {30'b0, occupancy_o}, 32'd1);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("stream drained valid_o", {31'b0, valid_o}, 32'd0);
        chk("stream drained data_o", data_o, 32'h3);

        // ---- skid fill and drain ----
        step(1'b1, 32'hCAFE_BABE, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
        chk("skid occ full", {30'b0, occupancy_o}, 32'd2);
        chk("skid ready_o", {31'b0, ready_o}, 32'd0);
        chk("skid data_o head", data_o, 32'hCAFE_BABE);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("skid drain data_o", data_o, 32'h1234_5678);
        chk("skid drain occ", {30'b0, occupancy_o}, 32'd1);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("skid empty valid_o", {31'b0, valid_o}, 32'd0);

        // ---- stall ----
        step(1'b1, 32'hAAAA_0001, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'hBBBB_0002, 1'b1, 1'b1, 1'b0);
            chk("stall data_o", data_o, 32'hAAAA_0001);
            chk("stall occ", {30'b0, occupancy_o}, 32'd1);
            chk("stall ready_o", {31'b0, ready_o}, 32'd0);
            chk("stall valid_o", {31'b0, valid_o}, 32'd1);
        end
        step(1'b1, 32'hBBBB_0002, 1'b1, 1'b0, 1'b0);
        chk("stall release data_o", data_o, 32'hBBBB_0002);
        chk("stall release occ", {30'b0, occupancy_o}, 32'd1);

        // ---- flush priority ----
        step(1'b1, 32'h0000_0011, 1'b0, 1'b0, 1'b0);
        chk("flush pre occ", {30'b0, occupancy_o}, 32'd2);
        step(1'b1, 32'h0000_0099, 1'b1, 1'b1, 1'b1);
        chk("flush occ", {30'b0, occupancy_o}, 32'd0);
        chk("flush valid_o", {31'b0, valid_o}, 32'd0);
        chk("flush data_o", data_o, 32'h0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("flush dropped beat valid_o", {31'b0, valid_o}, 32'd0);
        chk("flush dropped beat data_o", data_o, 32'h0);

`ifdef ELASTIC_STAGE_PERF_CNT_EN
        // ---- perf counters: 4 back-pressured cycles, 5 transfers ----
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        step(1'b1, 32'h50, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 32'h60 + i, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("perf bp_cycles_o", bp_cycles_o, 32'd4);
        chk("perf xfer_count_o", xfer_count_o, 32'd5);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("perf bp after flush", bp_cycles_o, 32'd4);
        chk("perf xfer after flush", xfer_count_o, 32'd5);
`endif

        // ---- randomized phase ----
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 29) == 0);
        end
        rst_n = 1'b1;
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
